sprite_capture: RTL and testbench

Frame-capture writer for the sprite store: on request, grabs a WIDTH×HEIGHT window from the live pixel stream at a latched origin, quantizes each pixel to an 8-bit RGB332 index, and drives the write port of the sprite image BRAM. It sits between the camera/video pipeline and the port B of the dual-port image RAM whose read side feeds the sprite renderer. Capture is one-shot per request, with a start/busy/done handshake to the gesture control logic.

---
 rtl/sprite_pkg.sv | 22 ++
 rtl/rgb332_quantize.sv | 13 +
 rtl/sprite_capture.sv | 163 ++++++++++++++++
 tb/tb_sprite_capture.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite store: capture FSM states, default window
// geometry and the RGB888 -> RGB332 palette index mapping.
package sprite_pkg;

    localparam int SPRITE_WIDTH  = 256;
    localparam int SPRITE_HEIGHT = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } capture_state_t;

    // index = {r[7:5], g[7:5], b[7:6]}; masks and shifts keep every input bit in the expression
    function automatic logic [7:0] rgb332(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
        return (r & 8'hE0) | ((g & 8'hE0) >> 3) | (b >> 6);
    endfunction

endpackage

// File: rtl/rgb332_quantize.sv
// Combinational RGB888 to 8-bit RGB332 palette index converter.
module rgb332_quantize
    import sprite_pkg::*;
(
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [7:0] index
);

    assign index = rgb332(red, green, blue);

endmodule

// File: rtl/sprite_capture.sv
// One-shot window grabber from the live pixel stream into the sprite image BRAM.
// Optional feature: define SPRITE_CAPTURE_CHECKSUM_EN to add checksum_out.
//
// state      | meaning
// IDLE       | waiting for start_in; origin latched on accept
// ARM        | waiting for the frame-start pixel (0,0)
// CAPTURE    | writing in-window pixels in raster order
// DONE       | single-cycle completion pulse
module sprite_capture
    import sprite_pkg::*;
#(
    parameter int  WIDTH  = SPRITE_WIDTH,
    parameter int  HEIGHT = SPRITE_HEIGHT,
    localparam int AW     = $clog2(WIDTH * HEIGHT)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_n_in,
    input  logic          start_in,
    input  logic [10:0]   x_in,
    input  logic [9:0]    y_in,
    input  logic [10:0]   hcount_in,
    input  logic [9:0]    vcount_in,
    input  logic          valid_in,
    input  logic [7:0]    red_in,
    input  logic [7:0]    green_in,
    input  logic [7:0]    blue_in,
    output logic [AW-1:0] wr_addr_out,
    output logic [7:0]    wr_data_out,
    output logic          wr_en_out,
    output logic          busy_out,
    output logic          done_out,
    output logic [AW:0]   pixels_out
`ifdef SPRITE_CAPTURE_CHECKSUM_EN
   ,output logic [15:0]   checksum_out
`endif
);

    localparam int          LOG2W = $clog2(WIDTH);
    localparam logic [AW:0] TOTAL = (AW + 1)'(WIDTH * HEIGHT);
    localparam logic [11:0] W_EXT = 12'(WIDTH);
    localparam logic [10:0] H_EXT = 11'(HEIGHT);

    capture_state_t state, state_next;

    logic [10:0]   x_q;
    logic [9:0]    y_q;
    logic [11:0]   h_end;
    logic [10:0]   v_end;
    logic [10:0]   h_off;
    logic [9:0]    v_off;
    logic          frame_start;
    logic          capture_active;
    logic          second_start;
    logic          in_window;
    logic          pix_write;
    logic          exit_capture;
    logic          accept_start;
    logic [AW:0]   pixels_next;
    logic [AW-1:0] addr_next;
    logic [7:0]    pix_index;

    rgb332_quantize u_quantize (
        .red   (red_in),
        .green (green_in),
        .blue  (blue_in),
        .index (pix_index)
    );

    // Widened end coordinates so a window near the screen edge never wraps
    assign h_end = {1'b0, x_q} + W_EXT;
    assign v_end = {1'b0, y_q} + H_EXT;
    assign h_off = hcount_in - x_q;
    assign v_off = vcount_in - y_q;

    assign frame_start    = valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign capture_active = (state == ST_CAPTURE) || ((state == ST_ARM) && frame_start);
    assign second_start   = (state == ST_CAPTURE) && frame_start;

    assign in_window = valid_in
                    && (hcount_in >= x_q) && ({1'b0, hcount_in} < h_end)
                    && (vcount_in >= y_q) && ({1'b0, vcount_in} < v_end);

    assign pix_write   = capture_active && in_window && !second_start;
    assign pixels_next = pix_write ? pixels_out + (AW + 1)'(1) : pixels_out;
    assign addr_next   = AW'((32'(v_off) << LOG2W) | 32'(h_off));

    // Second frame start means the rest of the window lies off-screen
    assign exit_capture = capture_active
                       && ((valid_in && ({1'b0, vcount_in} >= v_end))
                           || (pixels_next == TOTAL)
                           || second_start);

    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        busy_out     = 1'b0;
        done_out     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_in) begin
                    accept_start = 1'b1;
                    state_next   = ST_ARM;
                end
            end
            ST_ARM: begin
                busy_out = 1'b1;
                if (frame_start) begin
                    state_next = exit_capture ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                busy_out = 1'b1;
                if (exit_capture) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_out   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            pixels_out  <= '0;
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
        end else begin
            state     <= state_next;
            wr_en_out <= pix_write;
            if (accept_start) begin
                x_q        <= x_in;
                y_q        <= y_in;
                pixels_out <= '0;
            end else begin
                pixels_out <= pixels_next;
            end
            if (pix_write) begin
                wr_addr_out <= addr_next;
                wr_data_out <= pix_index;
            end
        end
    end

`ifdef SPRITE_CAPTURE_CHECKSUM_EN
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            checksum_out <= '0;
        end else if (accept_start) begin
            checksum_out <= '0;
        end else if (pix_write) begin
            checksum_out <= checksum_out + {8'd0, pix_index};
        end
    end
`endif

endmodule

// File: tb/tb_sprite_capture.sv
// Directed bench for sprite_capture (4x4 window, 8x8 frames) with a pixel-level model.
module tb_sprite_capture;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [10:0]   x_in;
    logic [9:0]    y_in;
    logic [10:0]   hc;
    logic [9:0]    vc;
    logic          valid;
    logic [7:0]    r, g, b;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          busy;
    logic          done;
    logic [AW:0]   pixels;
`ifdef SPRITE_CAPTURE_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    sprite_capture #(.WIDTH(W), .HEIGHT(H)) dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .start_in     (start),
        .x_in         (x_in),
        .y_in         (y_in),
        .hcount_in    (hc),
        .vcount_in    (vc),
        .valid_in     (valid),
        .red_in       (r),
        .green_in     (g),
        .blue_in      (b),
        .wr_addr_out  (wr_addr),
        .wr_data_out  (wr_data),
        .wr_en_out    (wr_en),
        .busy_out     (busy),
        .done_out     (done),
        .pixels_out   (pixels)
`ifdef SPRITE_CAPTURE_CHECKSUM_EN
       ,.checksum_out (checksum)
`endif
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;
    wr_t exp_q[$];

    // model state
    bit m_armed, m_capt, solid;
    int m_x, m_y, m_count, m_sum;
    int busy_from = 1 << 30;
    int busy_to   = 1 << 30;
    int exp_done  = -1;

    // observation state
    bit chk_en;
    int seen_mask, nwr, ndone, first_addr, first_data, first_cyc, origin_cyc, sum_at_done;
    bit got_first;

    task automatic end_capture();
        m_capt   = 0;
        exp_done = cyc + 1;
        busy_to  = cyc + 1;
    endtask

    task automatic pix(input int h, input int v, input bit vld, input bit st);
        int rr, gg, bb, idx;
        bit fs, first;
        if (solid) begin
            rr = 0; gg = 0; bb = 64;
        end else if (h == 0 && v == 0) begin
            rr = 255; gg = 128; bb = 64;
        end else begin
            rr = h * 32; gg = v * 32; bb = ((h + v) % 4) * 64;
        end
        @(posedge clk); #1;
        hc = 11'(h); vc = 10'(v); valid = vld; start = st;
        r = 8'(rr); g = 8'(gg); b = 8'(bb);
        idx = (rr / 32) * 32 + (gg / 32) * 4 + bb / 64;
        if (st && !m_armed && !m_capt && cyc > exp_done) begin
            m_armed = 1; m_count = 0; m_sum = 0;
            m_x = int'(x_in); m_y = int'(y_in);
            busy_from = cyc + 1; busy_to = 1 << 30;
        end else if (vld) begin
            fs = (h == 0 && v == 0);
            first = 0;
            if (m_armed && fs) begin
                m_armed = 0; m_capt = 1; first = 1; origin_cyc = cyc;
            end
            if (m_capt) begin
                if (fs && !first) begin
                    end_capture();
                end else if (h >= m_x && h < m_x + W && v >= m_y && v < m_y + H) begin
                    exp_q.push_back('{cyc + 1, (v - m_y) * W + (h - m_x), idx});
                    m_count++;
                    m_sum = (m_sum + idx) % 65536;
                    if (m_count == W * H) end_capture();
                end else if (v >= m_y + H) begin
                    end_capture();
                end
            end
        end
    endtask

    task automatic do_start(input int x, input int y);
        x_in = 11'(x); y_in = 10'(y);
        pix(0, 0, 0, 1);
        pix(0, 0, 0, 0);
    endtask

    task automatic run_frame(input int gap, input bit pulse);
        for (int v = 0; v < 8; v++) begin
            for (int h = 0; h < 8; h++) begin
                pix(h, v, 1, pulse && h == 1 && v == 1);
                for (int k = 0; k < gap; k++) pix(0, 0, 0, 0);
            end
        end
        pix(0, 0, 0, 0);
        pix(0, 0, 0, 0);
    endtask

    task automatic clear_obs();
        seen_mask = 0; nwr = 0; ndone = 0; got_first = 0;
        first_addr = -1; first_data = -1; first_cyc = -1; sum_at_done = -1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_armed = 0; m_capt = 0; m_count = 0; m_sum = 0;
        busy_from = 1 << 30; busy_to = 1 << 30; exp_done = -1;
    endtask

    task automatic end_checks(input string tag, input int exp_pixels, input int exp_mask);
        check(int'(pixels) == exp_pixels, {tag, "_pixels_out"}, int'(pixels), exp_pixels);
        check(int'(pixels) == m_count, {tag, "_pixels_vs_model"}, int'(pixels), m_count);
        check(seen_mask == exp_mask, {tag, "_addr_set"}, seen_mask, exp_mask);
        check(nwr == exp_pixels, {tag, "_write_count"}, nwr, exp_pixels);
        check(ndone == 1, {tag, "_done_pulses"}, ndone, 1);
        check(exp_q.size() == 0, {tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin : compare
        wr_t e;
        int exp_busy;
        if (chk_en) begin
            if (wr_en) begin
                check(exp_q.size() != 0, "unexpected_write", int'(wr_addr), -1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check(e.cyc == cyc, "write_latency", cyc, e.cyc);
                    check(e.addr == int'(wr_addr), "write_addr", int'(wr_addr), e.addr);
                    check(e.data == int'(wr_data), "write_data", int'(wr_data), e.data);
                end
                seen_mask = seen_mask | (1 << wr_addr);
                nwr++;
                if (!got_first) begin
                    got_first = 1; first_addr = int'(wr_addr);
                    first_data = int'(wr_data); first_cyc = cyc;
                end
            end
            check(int'(done) == int'(cyc == exp_done), "done_out", int'(done), int'(cyc == exp_done));
            exp_busy = int'(cyc >= busy_from && cyc < busy_to);
            check(int'(busy) == exp_busy, "busy_out", int'(busy), exp_busy);
            if (done) begin
                ndone++;
`ifdef SPRITE_CAPTURE_CHECKSUM_EN
                sum_at_done = int'(checksum);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0t required < 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0; start = 0; x_in = '0; y_in = '0; hc = '0; vc = '0; valid = 0;
        r = '0; g = '0; b = '0; chk_en = 0; solid = 0;
        clear_model();
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check(wr_en == 1'b0, "reset_wr_en", int'(wr_en), 0);
        check(wr_addr == '0, "reset_wr_addr", int'(wr_addr), 0);
        check(wr_data == '0, "reset_wr_data", int'(wr_data), 0);
        check(busy == 1'b0, "reset_busy", int'(busy), 0);
        check(done == 1'b0, "reset_done", int'(done), 0);
        check(pixels == '0, "reset_pixels", int'(pixels), 0);
`ifdef SPRITE_CAPTURE_CHECKSUM_EN
        check(checksum == '0, "reset_checksum", int'(checksum), 0);
`endif
        @(negedge clk);
        rst_n  = 1;
        chk_en = 1;

        // full window at the origin, origin pixel (FF,80,40) -> 0xF1
        clear_obs();
        do_start(0, 0);
        run_frame(0, 0);
        end_checks("full", 16, 16'hFFFF);
        check(first_addr == 0, "origin_addr", first_addr, 0);
        check(first_data == 8'hF1, "origin_data", first_data, 8'hF1);
        check(first_cyc == origin_cyc + 1, "origin_latency", first_cyc - origin_cyc, 1);

        // window clipped by the frame edge, ends at the next frame start
        clear_obs();
        do_start(6, 6);
        run_frame(0, 0);
        run_frame(0, 0);
        end_checks("clip", 4, 16'h0033);

        // gaps of invalid (0,0) cycles and a start pulse mid-capture
        clear_obs();
        do_start(0, 0);
        run_frame(3, 1);
        end_checks("gaps", 16, 16'hFFFF);

        // reset in the middle of a capture
        clear_obs();
        do_start(0, 0);
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < 8; h++) pix(h, v, 1, 0);
        pix(0, 2, 1, 0);
        pix(1, 2, 1, 0);
        @(posedge clk); #1;
        check(wr_en == 1'b1, "pre_reset_wr_en", int'(wr_en), 1);
        chk_en = 0;
        #2 rst_n = 0;
        #1;
        check(wr_en == 1'b0, "mid_reset_wr_en", int'(wr_en), 0);
        check(busy == 1'b0, "mid_reset_busy", int'(busy), 0);
        check(pixels == '0, "mid_reset_pixels", int'(pixels), 0);
        clear_model();
        @(negedge clk);
        rst_n = 1;
        clear_obs();
        chk_en = 1;
        do_start(0, 0);
        run_frame(0, 0);
        end_checks("after_reset", 16, 16'hFFFF);

`ifdef SPRITE_CAPTURE_CHECKSUM_EN
        // every pixel maps to index 0x01
        clear_obs();
        solid = 1;
        do_start(0, 0);
        run_frame(0, 0);
        end_checks("checksum", 16, 16'hFFFF);
        check(sum_at_done == 16, "checksum_at_done", sum_at_done, 16);
        check(int'(checksum) == m_sum, "checksum_vs_model", int'(checksum), m_sum);
        solid = 0;
`endif

        repeat (4) pix(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
